uart_bus_bridge: RTL and testbench

UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

---
 rtl/uart_bus_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: turns framed bytes from a UART receiver into single
// peripheral bus accesses and returns a response frame to the transmitter.
// Frame: cmd, addr_hi, addr_lo, then for writes 4 data bytes MSB first.
// Handshakes: rxDataAvailable is a one-cycle strobe that is sampled every
// cycle with no back-pressure. A tx byte is taken on the cycle where
// txDataAvailable && !txBusy. A bus access completes on the first
// BUS cycle with peripheralBus_busy low.
module uart_bus_bridge #(
    parameter int BUS_TIMEOUT   = 255,
    parameter int FRAME_TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rxData,
    input  logic        rxDataAvailable,
    output logic [7:0]  txData,
    output logic        txDataAvailable,
    input  logic        txBusy,
    output logic        peripheralEnable,
    output logic        peripheralBus_we,
    output logic        peripheralBus_oe,
    input  logic        peripheralBus_busy,
    output logic [15:0] peripheralBus_address,
    output logic [3:0]  peripheralBus_byteSelect,
    output logic [31:0] peripheralBus_dataWrite,
    input  logic [31:0] peripheralBus_dataRead,
    output logic        bridgeActive,
    output logic        rxOverrun
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR_H = 3'd1,
        ST_ADDR_L = 3'd2,
        ST_DATA   = 3'd3,
        ST_BUS    = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    localparam int              BCW        = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [BCW-1:0]  BUS_LAST   = BCW'(BUS_TIMEOUT - 1);
    localparam logic [15:0]     FRAME_LAST = 16'(FRAME_TIMEOUT - 1);
    localparam logic [7:0]      ACK        = 8'h06;
    localparam logic [7:0]      NAK        = 8'h15;

    state_e          state_q, state_d;
    logic [1:0]      rst_sync_q;
    logic            is_write_q, is_write_d;
    logic [3:0]      bs_q, bs_d;
    logic [15:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [BCW-1:0]  bus_cnt_q, bus_cnt_d;
    logic [31:0]     resp_q, resp_d;
    logic [1:0]      resp_left_q, resp_left_d;
    logic            overrun_q, overrun_d;

    logic            rx_stb;
    logic            cmd_ok;
    logic            tx_accept;
    logic            frame_expired;

    // Strobes are ignored until the released reset has crossed both sync flops.
    assign rx_stb        = rxDataAvailable & rst_sync_q[1];
    assign cmd_ok        = (rxData[3:1] == 3'b000);
    assign tx_accept     = (state_q == ST_RESP) & ~txBusy;
    assign frame_expired = (frame_cnt_q == FRAME_LAST);

    // Reset release synchroniser; assertion stays asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_stb) state_d = cmd_ok ? ST_ADDR_H : ST_RESP;
            end
            ST_ADDR_H: begin
                if (rx_stb)             state_d = ST_ADDR_L;
                else if (frame_expired) state_d = ST_IDLE;
            end
            ST_ADDR_L: begin
                if (rx_stb)             state_d = is_write_q ? ST_DATA : ST_BUS;
                else if (frame_expired) state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (rx_stb) begin
                    if (byte_cnt_q == 2'd3) state_d = ST_BUS;
                end else if (frame_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (!peripheralBus_busy || bus_cnt_q == BUS_LAST) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (tx_accept && resp_left_q == 2'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state and held frame registers.
    always_comb begin
        peripheralEnable         = (state_q == ST_BUS);
        peripheralBus_we         = (state_q == ST_BUS) &  is_write_q;
        peripheralBus_oe         = (state_q == ST_BUS) & ~is_write_q;
        peripheralBus_address    = addr_q;
        peripheralBus_byteSelect = bs_q;
        peripheralBus_dataWrite  = wdata_q;
        txDataAvailable          = (state_q == ST_RESP);
        txData                   = (state_q == ST_RESP) ? resp_q[31:24] : 8'h00;
        bridgeActive             = (state_q != ST_IDLE);
        rxOverrun                = overrun_q;
    end

    // Datapath next values: frame capture, timeouts, response shifting.
    always_comb begin
        is_write_d  = is_write_q;
        bs_d        = bs_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        byte_cnt_d  = byte_cnt_q;
        frame_cnt_d = 16'd0;
        bus_cnt_d   = '0;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        overrun_d   = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_stb) begin
                    if (cmd_ok) begin
                        is_write_d = rxData[0];
                        bs_d       = rxData[7:4];
                        wdata_d    = 32'd0;
                    end else begin
                        resp_d      = {NAK, 24'd0};
                        resp_left_d = 2'd0;
                    end
                end
            end
            ST_ADDR_H: begin
                frame_cnt_d = rx_stb ? 16'd0 : frame_cnt_q + 16'd1;
                if (rx_stb) addr_d[15:8] = rxData;
            end
            ST_ADDR_L: begin
                frame_cnt_d = rx_stb ? 16'd0 : frame_cnt_q + 16'd1;
                if (rx_stb) begin
                    addr_d[7:0] = rxData;
                    byte_cnt_d  = 2'd0;
                end
            end
            ST_DATA: begin
                frame_cnt_d = rx_stb ? 16'd0 : frame_cnt_q + 16'd1;
                if (rx_stb) begin
                    wdata_d    = {wdata_q[23:0], rxData};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            ST_BUS: begin
                overrun_d = overrun_q | rx_stb;
                if (!peripheralBus_busy) begin
                    if (is_write_q) begin
                        resp_d      = {ACK, 24'd0};
                        resp_left_d = 2'd0;
                    end else begin
                        resp_d      = peripheralBus_dataRead;
                        resp_left_d = 2'd3;
                    end
                end else if (bus_cnt_q == BUS_LAST) begin
                    resp_d      = {NAK, 24'd0};
                    resp_left_d = 2'd0;
                end else begin
                    bus_cnt_d = bus_cnt_q + BCW'(1);
                end
            end
            ST_RESP: begin
                overrun_d = overrun_q | rx_stb;
                if (tx_accept) begin
                    resp_d = {resp_q[23:0], 8'h00};
                    if (resp_left_q != 2'd0) resp_left_d = resp_left_q - 2'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write_q  <= 1'b0;
            bs_q        <= 4'd0;
            addr_q      <= 16'd0;
            wdata_q     <= 32'd0;
            byte_cnt_q  <= 2'd0;
            frame_cnt_q <= 16'd0;
            bus_cnt_q   <= '0;
            resp_q      <= 32'd0;
            resp_left_q <= 2'd0;
            overrun_q   <= 1'b0;
        end else begin
            is_write_q  <= is_write_d;
            bs_q        <= bs_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            byte_cnt_q  <= byte_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            bus_cnt_q   <= bus_cnt_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Testbench for uart_bus_bridge: frame-level model predicts bus accesses and
// response bytes; one compare process checks the DUT on every falling edge.
module tb_uart_bus_bridge;
  localparam int BUS_TIMEOUT   = 255;
  localparam int FRAME_TIMEOUT = 65535;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxDataAvailable = 1'b0;
  logic [7:0]  txData;
  logic        txDataAvailable;
  logic        txBusy = 1'b0;
  logic        peripheralEnable;
  logic        peripheralBus_we;
  logic        peripheralBus_oe;
  logic        peripheralBus_busy = 1'b0;
  logic [15:0] peripheralBus_address;
  logic [3:0]  peripheralBus_byteSelect;
  logic [31:0] peripheralBus_dataWrite;
  logic [31:0] peripheralBus_dataRead = 32'h0;
  logic        bridgeActive;
  logic        rxOverrun;

  always #5 clk = ~clk;

  uart_bus_bridge #(.BUS_TIMEOUT(BUS_TIMEOUT), .FRAME_TIMEOUT(FRAME_TIMEOUT)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .rxData                   (rxData),
    .rxDataAvailable          (rxDataAvailable),
    .txData                   (txData),
    .txDataAvailable          (txDataAvailable),
    .txBusy                   (txBusy),
    .peripheralEnable         (peripheralEnable),
    .peripheralBus_we         (peripheralBus_we),
    .peripheralBus_oe         (peripheralBus_oe),
    .peripheralBus_busy       (peripheralBus_busy),
    .peripheralBus_address    (peripheralBus_address),
    .peripheralBus_byteSelect (peripheralBus_byteSelect),
    .peripheralBus_dataWrite  (peripheralBus_dataWrite),
    .peripheralBus_dataRead   (peripheralBus_dataRead),
    .bridgeActive             (bridgeActive),
    .rxOverrun                (rxOverrun)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  bs;
    logic [31:0] data;
    logic        we;
    logic [15:0] dur;
  } acc_t;

  logic [7:0] exp_q[$];
  acc_t       acc_q[$];
  logic [7:0] rx_log[$];
  int n_cmp = 0;
  int n_fail = 0;
  int last_dur = 0;
  int n_acc = 0;

  // bench-side responder / sink controls
  int busy_cycles = 0;
  int bus_n = 0;
  int tx_mode = 0;
  int cyc = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  function automatic logic [31:0] log_word();
    logic [31:0] w = 32'h0;
    foreach (rx_log[i]) w = {w[23:0], rx_log[i]};
    return w;
  endfunction

  // ---------------- model ----------------
  task automatic expect_frame(input logic [7:0] cmd, input logic [15:0] addr,
                              input logic [31:0] wdata, input int busy_n, input logic [31:0] rdata);
    acc_t a;
    if (cmd[3:1] != 3'b000) begin
      exp_q.push_back(8'h15);
    end else begin
      a.addr = addr;
      a.bs   = cmd[7:4];
      a.we   = cmd[0];
      a.data = wdata;
      if (busy_n >= BUS_TIMEOUT) begin
        a.dur = 16'(BUS_TIMEOUT);
        exp_q.push_back(8'h15);
      end else begin
        a.dur = 16'(busy_n + 1);
        if (cmd[0]) exp_q.push_back(8'h06);
        else for (int i = 3; i >= 0; i--) exp_q.push_back(rdata[8*i +: 8]);
      end
      acc_q.push_back(a);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rxData = b;
    rxDataAvailable = 1'b1;
    @(posedge clk); #1;
    rxDataAvailable = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr,
                            input logic [31:0] wdata, input int gap);
    send_byte(cmd);
    if (cmd[3:1] == 3'b000) begin
      repeat (gap) @(posedge clk);
      send_byte(addr[15:8]);
      repeat (gap) @(posedge clk);
      send_byte(addr[7:0]);
      if (cmd[0]) begin
        for (int i = 3; i >= 0; i--) begin
          repeat (gap) @(posedge clk);
          send_byte(wdata[8*i +: 8]);
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk); #1;
    while ((bridgeActive || exp_q.size() != 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("return_idle", 64'(bridgeActive), 64'd0);
    check("resp_drained", 64'(exp_q.size()), 64'd0);
    check("acc_drained", 64'(acc_q.size()), 64'd0);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr,
                           input logic [31:0] wdata, input int busy_n, input logic [31:0] rdata,
                           input int gap);
    busy_cycles = busy_n;
    peripheralBus_dataRead = rdata;
    rx_log.delete();
    expect_frame(cmd, addr, wdata, busy_n, rdata);
    send_frame(cmd, addr, wdata, gap);
    wait_idle(600);
  endtask

  // bus responder and tx sink, driven just after each rising edge
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (peripheralEnable) begin
        peripheralBus_busy = (bus_n < busy_cycles);
        bus_n++;
      end else begin
        peripheralBus_busy = 1'b0;
        bus_n = 0;
      end
      case (tx_mode)
        0:       txBusy = 1'b0;
        1:       txBusy = (cyc % 3 != 0);
        default: txBusy = 1'b1;
      endcase
    end
  end

  // ---------------- compare process ----------------
  initial begin
    int dur = 0;
    logic prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dur = 0;
        prev_hold = 1'b0;
      end else begin
        if (peripheralEnable) begin
          if (acc_q.size() == 0) begin
            fail_now("unexpected_access");
          end else begin
            check("bus_addr", 64'(peripheralBus_address), 64'(acc_q[0].addr));
            check("bus_bs", 64'(peripheralBus_byteSelect), 64'(acc_q[0].bs));
            check("bus_we_oe", 64'({peripheralBus_we, peripheralBus_oe}), acc_q[0].we ? 64'd2 : 64'd1);
            if (acc_q[0].we) check("bus_wdata", 64'(peripheralBus_dataWrite), 64'(acc_q[0].data));
            dur++;
          end
        end else begin
          check("strobes_low", 64'({peripheralBus_we, peripheralBus_oe}), 64'd0);
          if (dur > 0) begin
            check("bus_dur", 64'(dur), 64'(acc_q[0].dur));
            last_dur = dur;
            void'(acc_q.pop_front());
            n_acc++;
            dur = 0;
          end
        end
        if (prev_hold) check("tx_stable", 64'({txDataAvailable, txData}), 64'({1'b1, prev_data}));
        if (txDataAvailable && !txBusy) begin
          rx_log.push_back(txData);
          if (exp_q.size() == 0) fail_now("unexpected_tx");
          else check("tx_byte", 64'(txData), 64'(exp_q.pop_front()));
        end
        prev_hold = txDataAvailable && txBusy;
        prev_data = txData;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n_acc0;
    int n;
    // reset values
    #12;
    check("rst_flags", 64'({txDataAvailable, peripheralEnable, peripheralBus_we, peripheralBus_oe,
                           bridgeActive, rxOverrun}), 64'd0);
    check("rst_bus_fields", 64'({peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite}), 64'd0);
    check("rst_txdata", 64'(txData), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // write, zero wait states
    tx_mode = 0;
    run_frame(8'hF1, 16'h1014, 32'h0000_0041, 0, 32'h0, 0);
    check("wr_dur_lit", 64'(last_dur), 64'd1);
    check("wr_resp_lit", 64'(rx_log.size() == 1 ? rx_log[0] : 8'hxx), 64'h06);

    // read, three busy cycles, toggling tx sink
    tx_mode = 1;
    run_frame(8'h30, 16'h1008, 32'h0, 3, 32'hA1B2_C3D4, 0);
    check("rd_dur_lit", 64'(last_dur), 64'd4);
    check("rd_nbytes_lit", 64'(rx_log.size()), 64'd4);
    check("rd_bytes_lit", 64'(log_word()), 64'hA1B2_C3D4);

    // invalid commands: NAK, no access
    tx_mode = 0;
    n_acc0 = n_acc;
    run_frame(8'h02, 16'h0, 32'h0, 0, 32'h0, 0);
    check("inv_resp_lit", 64'(log_word()), 64'h15);
    run_frame(8'hFE, 16'h0, 32'h0, 0, 32'h0, 0);
    check("inv2_resp_lit", 64'(log_word()), 64'h15);
    check("inv_no_access", 64'(n_acc), 64'(n_acc0));

    // bus timeout: responder stuck busy
    run_frame(8'h51, 16'h2222, 32'hDEAD_BEEF, 1000, 32'h0, 0);
    check("to_dur_lit", 64'(last_dur), 64'd255);
    check("to_resp_lit", 64'(log_word()), 64'h15);

    // longest successful access: busy for BUS_TIMEOUT-1 cycles, gaps between bytes
    tx_mode = 1;
    run_frame(8'h70, 16'hFFFF, 32'h0, 254, 32'h0BAD_F00D, 7);
    check("edge_dur_lit", 64'(last_dur), 64'd255);
    check("edge_bytes_lit", 64'(log_word()), 64'h0BAD_F00D);

    // frame timeout after lone command byte
    tx_mode = 0;
    rx_log.delete();
    send_byte(8'h31);
    repeat (FRAME_TIMEOUT - 1) @(posedge clk);
    @(negedge clk);
    check("frame_to_before", 64'(bridgeActive), 64'd1);
    @(posedge clk); @(negedge clk);
    check("frame_to_after", 64'(bridgeActive), 64'd0);
    check("frame_to_no_tx", 64'(rx_log.size()), 64'd0);
    run_frame(8'h31, 16'h0102, 32'h1122_3344, 2, 32'h0, 3);
    check("after_to_resp_lit", 64'(log_word()), 64'h06);

    // overrun during BUS, then reset while a response is stalled
    check("ovr_clear", 64'(rxOverrun), 64'd0);
    tx_mode = 2;
    busy_cycles = 5;
    peripheralBus_dataRead = 32'h5566_7788;
    rx_log.delete();
    expect_frame(8'h10, 16'h0304, 32'h0, 5, 32'h5566_7788);
    send_frame(8'h10, 16'h0304, 32'h0, 0);
    send_byte(8'hF1);
    n = 0;
    @(negedge clk);
    while (!txDataAvailable && n < 50) begin @(negedge clk); n++; end
    check("ovr_reached_resp", 64'(txDataAvailable), 64'd1);
    check("ovr_set", 64'(rxOverrun), 64'd1);
    check("ovr_dur_lit", 64'(last_dur), 64'd6);
    check("resp_stall_lit", 64'(txData), 64'h55);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_flags", 64'({txDataAvailable, rxOverrun, bridgeActive, peripheralEnable}), 64'd0);
    check("rst_mid_txdata", 64'(txData), 64'd0);
    exp_q.delete();
    acc_q.delete();
    tx_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    check("rst_no_resp", 64'(rx_log.size()), 64'd0);
    run_frame(8'h81, 16'hABCD, 32'hCAFE_0001, 1, 32'h0, 0);
    check("recover_resp_lit", 64'(log_word()), 64'h06);
    check("recover_ovr", 64'(rxOverrun), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
